// File: rtl/match_controller_pkg.sv
// Shared types and constants for the match controller: FSM state encoding,
// score type and the CPU-opponent LFSR seed/tap constants.
package match_controller_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [2:0] score_t;

  localparam int             LFSR_W    = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;
  // Taps for x^10 + x^7 + 1: feedback is bit 9 XOR bit 6.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/match_controller_lfsr.sv
// match_lfsr: free-running 10-bit Fibonacci LFSR that produces the computer
// opponent's press. A press is asserted when the low three bits fall below
// the requested aggressiveness level. Only built when MATCH_CPU_EN is defined.
module match_lfsr
  import match_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] level,
  output logic       press
);

  logic [LFSR_W-1:0] lfsr;

  // Advance the LFSR every clock; reset returns it to the fixed seed.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  assign press = (lfsr[2:0] < level);

endmodule

// File: rtl/match_controller.sv
// match_controller: rally/score/pause sequencing for a two-player light game.
// PLAY forwards gated presses and detects points, HOLD pauses between rallies
// and issues a playfield re-centre pulse, OVER freezes the result until a new
// game is requested. Optional build macro MATCH_CPU_EN replaces the left
// player with an LFSR-driven computer opponent.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       edgeL,
  input  logic       edgeR,
  input  logic       newGame,
  input  logic [2:0] cpuLevel,
  output logic       moveL,
  output logic       moveR,
  output logic       fieldReset,
  output score_t     scoreL,
  output score_t     scoreR,
  output logic       gameOver,
  output logic       winnerL
);

  localparam score_t     WIN_VAL   = score_t'(WIN_SCORE);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  state_t     state, state_d;
  score_t     score_l_d, score_r_d;
  logic       over_d, winner_l_d;
  logic [7:0] count, count_d;
  logic       lsrc;
  logic       point_l, point_r;

`ifdef MATCH_CPU_EN
  // The physical left button is not used when the computer plays left.
  logic unused_l;
  assign unused_l = L;

  match_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .level (cpuLevel),
    .press (lsrc)
  );
`else
  // Aggressiveness only matters for the computer opponent.
  logic unused_cpu_level;
  assign unused_cpu_level = ^cpuLevel;
  assign lsrc = L;
`endif

  // Presses are forwarded only during a rally; a simultaneous pair cancels.
  assign moveL      = (state == PLAY) & lsrc & ~R;
  assign moveR      = (state == PLAY) & R & ~lsrc;
  assign point_l    = moveL & edgeL;
  assign point_r    = moveR & edgeR;
  assign fieldReset = (state == HOLD) && (count == 8'd1);

  // Next-state and next-score logic; newGame overrides everything else.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state;
    score_l_d  = scoreL;
    score_r_d  = scoreR;
    over_d     = gameOver;
    winner_l_d = winnerL;
    count_d    = count;

    unique case (state)
      PLAY: begin
        if (point_l) begin
          score_l_d = scoreL + 3'd1;
          if (score_l_d == WIN_VAL) begin
            state_d    = OVER;
            over_d     = 1'b1;
            winner_l_d = 1'b1;
          end else begin
            state_d = HOLD;
            count_d = HOLD_LOAD;
          end
        end else if (point_r) begin
          score_r_d = scoreR + 3'd1;
          if (score_r_d == WIN_VAL) begin
            state_d    = OVER;
            over_d     = 1'b1;
            winner_l_d = 1'b0;
          end else begin
            state_d = HOLD;
            count_d = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        count_d = count - 8'd1;
        if (count <= 8'd1) begin
          state_d = PLAY;
          count_d = 8'd0;
        end
      end
      OVER: begin
        // Result is frozen until a new game is requested.
      end
      default: state_d = PLAY;
    endcase

    if (newGame) begin
      score_l_d  = '0;
      score_r_d  = '0;
      over_d     = 1'b0;
      winner_l_d = 1'b0;
      state_d    = HOLD;
      count_d    = HOLD_LOAD;
    end
  end

  // State, score and pause-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      scoreL   <= '0;
      scoreR   <= '0;
      gameOver <= 1'b0;
      winnerL  <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_d;
      scoreL   <= score_l_d;
      scoreR   <= score_r_d;
      gameOver <= over_d;
      winnerL  <= winner_l_d;
      count    <= count_d;
    end
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter WIN_SCORE, default 3, points needed to win the match (legal range 1..7).
REQ-002 Parameter HOLD_CYCLES, default 4, pause length in clocks between a point and the next rally (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 L  input  1  left-player press pulse, one cycle per press, already synchronised.
REQ-006 R  input  1  right-player press pulse, one cycle per press, already synchronised.
REQ-007 edgeL  input  1  leftmost playfield light is lit.
REQ-008 edgeR  input  1  rightmost playfield light is lit.
REQ-009 newGame  input  1  request to restart the match.
REQ-010 cpuLevel  input  3  computer-opponent aggressiveness (0 = never presses, 7 = most often).
REQ-011 moveL  output  1  gated left press forwarded to the playfield.
REQ-012 moveR  output  1  gated right press forwarded to the playfield.
REQ-013 fieldReset  output  1  one-cycle playfield re-centre pulse, ORed with the board reset at top level.
REQ-014 scoreL  output  3  left-player points.
REQ-015 scoreR  output  3  right-player points.
REQ-016 gameOver  output  1  match finished.
REQ-017 winnerL  output  1  when gameOver is high: 1 = left won, 0 = right won.

Function
REQ-018 States SHALL be PLAY, HOLD and OVER.
REQ-019 moveL SHALL equal (state==PLAY) & Lsrc & ~R, and moveR SHALL equal (state==PLAY) & R & ~Lsrc, combinationally in the same cycle; simultaneous presses SHALL cancel.
REQ-020 Lsrc SHALL be L without MATCH_CPU_EN and the CPU press with it (REQ-031).
REQ-021 In PLAY, moveL & edgeL SHALL score a left point and moveR & edgeR SHALL score a right point; the score SHALL increment on the next clock edge.
REQ-022 If a point brings the scorer to WIN_SCORE, the next state SHALL be OVER; gameOver SHALL be 1 and winnerL SHALL identify the scorer.
REQ-023 Otherwise the next state SHALL be HOLD, with the down-counter loaded to HOLD_CYCLES.
REQ-024 In HOLD the counter SHALL decrement every cycle and both move outputs SHALL be 0.
REQ-025 fieldReset SHALL be high exactly in the HOLD cycle where the counter equals 1; the next state after that cycle SHALL be PLAY.
REQ-026 OVER SHALL hold the scores and winnerL, keep fieldReset at 0, gate all moves, and leave only on newGame.
REQ-027 newGame in any state SHALL clear both scores and gameOver, and SHALL enter HOLD with the counter reloaded; newGame SHALL take priority over a same-cycle point.
REQ-028 If edgeL and edgeR are both high, only the side with a forwarded move SHALL score; scores SHALL never exceed WIN_SCORE.

Reset
REQ-029 Reset SHALL force state PLAY, scoreL=0, scoreR=0, gameOver=0, winnerL=0, counter=0 and fieldReset=0; moveL and moveR SHALL follow REQ-019.
REQ-030 Reset asserted mid-HOLD or in OVER SHALL abort immediately with no fieldReset pulse.

Configuration
REQ-031 With MATCH_CPU_EN defined, the L input SHALL be ignored. The left press SHALL come from a 10-bit LFSR (x^10+x^7+1, seed 10'h001 on reset, advancing every cycle), asserted when lfsr[2:0] < cpuLevel.
REQ-032 Without MATCH_CPU_EN, no LFSR SHALL be built, cpuLevel SHALL be ignored and Lsrc SHALL equal L.

Structure
REQ-033 A shared package SHALL hold the state enum, the 3-bit score typedef and the LFSR seed/tap constants.
REQ-034 The LFSR SHALL be a sub-module named match_lfsr, instantiated only under MATCH_CPU_EN.

Verification
REQ-035 Reset, then L and R pulsed in the same cycle -> moveL=0, moveR=0, scores stay 0.
REQ-036 edgeR=1 and an R pulse -> moveR=1 that cycle, scoreR=1 next cycle, fieldReset high exactly 4 cycles later, then PLAY; an L pulse during HOLD -> moveL=0.
REQ-037 Three right points -> scoreR=3, gameOver=1, winnerL=0, no fieldReset; further presses -> moves stay 0.
REQ-038 newGame in OVER -> scores 0, gameOver 0, one fieldReset pulse after 4 cycles, PLAY resumes.
REQ-039 Reset asserted at HOLD counter=2 -> state PLAY, scores 0, fieldReset never pulses.
REQ-040 With MATCH_CPU_EN and cpuLevel=0 -> moveL never asserts over 1023 cycles; with cpuLevel=7 -> moveL pulses, and L is ignored.
